sram_responder: RTL and testbench

//  Bus-side model/controller that answers the SLC-3 external-SRAM bus: CE/UB/LB/OE/WE,
//  20-bit ADDR and the 16-bit bidirectional Data line.
//  It sits where the off-chip 1Mx16 SRAM would, behind the CPU's tristate buffer.

---
 rtl/sram_resp_pkg.sv | 20 ++
 rtl/byte_lane_ram.sv | 23 ++
 rtl/sram_responder.sv | 161 ++++++++++++++++
 tb/tb_sram_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SLC-3 external-SRAM bus responder.
// Holds the FSM encoding, latency bound and out-of-range read fill value.
package sram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    DRIVE,
    WRITE
  } state_t;

  localparam int          READ_LAT_MAX = 15;
  localparam logic [15:0] RANGE_FILL   = 16'h0000;

  // True when the word address has bits set above the backed storage.
  function automatic logic out_of_range(input logic [19:0] addr, input int aw);
    return (addr >> aw) != 20'd0;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Synchronous-write 2**AW x 16 storage with per-byte write enables.
// Single write port, asynchronous read; never stalls.
module byte_lane_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:2**AW-1];

  always_ff @(posedge clk) begin
    if (we[1]) mem[waddr][15:8] <= wdata[15:8];
    if (we[0]) mem[waddr][7:0]  <= wdata[7:0];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sram_responder.sv
// Stands in for the off-chip 1Mx16 SRAM on the SLC-3 bus, with an init preload port.
// Reads drive Data READ_LAT cycles after acceptance; writes commit when WE or CE rises.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int AW       = 10,
  parameter int READ_LAT = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          CE,
  input  logic          UB,
  input  logic          LB,
  input  logic          OE,
  input  logic          WE,
  input  logic [19:0]   ADDR,
  inout  wire  [15:0]   Data,
  input  logic          Init_WE,
  input  logic [AW-1:0] Init_ADDR,
  input  logic [15:0]   Init_Data,
  output logic          Busy,
  output logic          Err_range,
  output logic          Err_conflict
);

  localparam int             CW        = $clog2(READ_LAT_MAX + 1);
  localparam logic [CW-1:0]  LAT       = CW'(READ_LAT);
  localparam state_t         RD_TARGET = (READ_LAT == 0) ? DRIVE : READ_WAIT;

  state_t        state, state_n;
  logic [19:0]   addr_q, addr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   wdata_q, wdata_n;
  logic [1:0]    be_q, be_n;
  logic          range_n;
  logic          sample_wr;
  logic          load_rd;
  logic          commit;

  logic [1:0]    ram_we;
  logic [AW-1:0] ram_waddr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;
  logic [15:0]   rd_word;
  logic          bus_wr;
  logic          init_ok;
  logic          drive_en;

  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    cnt_n     = cnt;
    wdata_n   = wdata_q;
    be_n      = be_q;
    range_n   = 1'b0;
    sample_wr = 1'b0;
    load_rd   = 1'b0;
    commit    = 1'b0;

    unique case (state)
      IDLE: begin
        if (!CE && !WE) begin
          state_n   = WRITE;
          sample_wr = 1'b1;
        end else if (!CE && !OE) begin
          load_rd = 1'b1;
        end
      end
      READ_WAIT: begin
        if (CE || OE) begin
          state_n = IDLE;
        end else if (!WE) begin
          state_n   = WRITE;
          sample_wr = 1'b1;
        end else if (ADDR != addr_q) begin
          load_rd = 1'b1;
        end else if (cnt <= CW'(1)) begin
          state_n = DRIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DRIVE: begin
        if (CE || OE) begin
          state_n = IDLE;
        end else if (!WE) begin
          state_n   = WRITE;
          sample_wr = 1'b1;
        end else if (ADDR != addr_q) begin
          load_rd = 1'b1;
        end
      end
      WRITE: begin
        if (!CE && !WE) begin
          sample_wr = 1'b1;
        end else begin
          commit  = 1'b1;
          range_n = out_of_range(addr_q, AW);
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (sample_wr) begin
      addr_n  = ADDR;
      wdata_n = Data;
      be_n    = {~UB, ~LB};
    end
    if (load_rd) begin
      state_n = RD_TARGET;
      addr_n  = ADDR;
      cnt_n   = LAT;
      range_n = out_of_range(ADDR, AW);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      cnt          <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      Err_range    <= 1'b0;
      Err_conflict <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      cnt       <= cnt_n;
      wdata_q   <= wdata_n;
      be_q      <= be_n;
      Err_range <= range_n;
      if (!CE && !OE && !WE) Err_conflict <= 1'b1;
    end
  end

  // Bus commits only happen in WRITE and init only in IDLE, so the mux never collides.
  assign bus_wr    = commit && !out_of_range(addr_q, AW);
  assign init_ok   = Init_WE && (state == IDLE) && CE;
  assign ram_we    = bus_wr ? be_q : (init_ok ? 2'b11 : 2'b00);
  assign ram_waddr = bus_wr ? addr_q[AW-1:0] : Init_ADDR;
  assign ram_wdata = bus_wr ? wdata_q : Init_Data;

  byte_lane_ram #(.AW(AW)) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (addr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign rd_word    = out_of_range(addr_q, AW) ? RANGE_FILL : ram_rdata;
  assign drive_en   = (state == DRIVE) && !CE && !OE && WE;
  assign Data[15:8] = (drive_en && !UB) ? rd_word[15:8] : 8'hzz;
  assign Data[7:0]  = (drive_en && !LB) ? rd_word[7:0]  : 8'hzz;
  assign Busy       = (state != IDLE);

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded random bench for sram_responder; the Data net is pulled up so a
// released lane reads back as 8'hFF.
module tb_sram_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic          Clk;
  logic          Reset;
  logic          CE, UB, LB, OE, WE;
  logic [19:0]   ADDR;
  tri1  [15:0]   Data;
  logic          Init_WE;
  logic [AW-1:0] Init_ADDR;
  logic [15:0]   Init_Data;
  logic          Busy, Err_range, Err_conflict;

  logic          tb_drv;
  logic [15:0]   tb_dat;
  assign Data = tb_drv ? tb_dat : 16'hzzzz;

  sram_responder #(.AW(AW), .READ_LAT(LAT)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .CE           (CE),
    .UB           (UB),
    .LB           (LB),
    .OE           (OE),
    .WE           (WE),
    .ADDR         (ADDR),
    .Data         (Data),
    .Init_WE      (Init_WE),
    .Init_ADDR    (Init_ADDR),
    .Init_Data    (Init_Data),
    .Busy         (Busy),
    .Err_range    (Err_range),
    .Err_conflict (Err_conflict)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain word array plus the bus rules.
  logic [15:0] mem_m [0:2**AW-1];
  logic [15:0] exp_q [$];

  function automatic bit oor(input logic [19:0] a);
    return a >= (20'd1 << AW);
  endfunction

  function automatic logic [15:0] pat(input logic [19:0] a, input logic ub, input logic lb);
    logic [15:0] w;
    logic [9:0]  idx;
    idx = a[9:0];
    w = oor(a) ? 16'h0000 : mem_m[idx];
    return {ub ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]};
  endfunction

  // Monitor: follows each read the bus presents and compares against the queue.
  bit          mon_en = 0;
  bit          mon_active = 0;
  int          mon_n = 0;
  logic [15:0] mon_exp;

  always @(negedge Clk) begin
    if (mon_active) begin
      if (CE || OE) begin
        check("rd_release", Data, 16'hFFFF);
        mon_active = 0;
      end else begin
        mon_n++;
        if (mon_n > LAT) check("rd_data", Data, mon_exp);
        else             check("rd_latency_z", Data, 16'hFFFF);
      end
    end else if (mon_en && !CE && !OE && WE) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: read seen with no expected entry at %0t", $time);
      end else begin
        mon_exp    = exp_q.pop_front();
        mon_n      = 0;
        mon_active = 1;
        check("rd_accept_z", Data, 16'hFFFF);
      end
    end
  end

  task automatic init_write(input logic [AW-1:0] a, input logic [15:0] d);
    @(posedge Clk); #1;
    Init_WE = 1; Init_ADDR = a; Init_Data = d;
    @(posedge Clk); #1;
    Init_WE = 0;
    mem_m[a] = d;
  endtask

  task automatic do_read(input logic [19:0] a, input logic ub, input logic lb);
    @(posedge Clk); #1;
    exp_q.push_back(pat(a, ub, lb));
    CE = 0; OE = 0; WE = 1; UB = ub; LB = lb; ADDR = a;
    @(posedge Clk); #1;
    check("rd_err_range", Err_range, oor(a));
    check("rd_busy", Busy, 1);
    repeat (LAT + 2) @(posedge Clk);
    #1 CE = 1; OE = 1; UB = 1; LB = 1;
  endtask

  // Earlier cycles carry junk samples; only the final cycle's values may land.
  task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                          input logic ub, input logic lb, input int ncyc);
    logic [9:0] idx;
    @(posedge Clk); #1;
    CE = 0; WE = 0; OE = 1; tb_drv = 1;
    for (int i = 0; i < ncyc; i++) begin
      if (i == ncyc - 1) begin
        ADDR = a; tb_dat = d; UB = ub; LB = lb;
      end else begin
        ADDR = 20'($urandom_range(0, 31)); tb_dat = 16'($urandom);
        UB = 1'($urandom); LB = 1'($urandom);
      end
      if (i != 0) begin
        check("wr_busy", Busy, 1);
      end
      @(posedge Clk); #1;
    end
    CE = 1; WE = 1; tb_drv = 0; UB = 1; LB = 1;
    @(posedge Clk); #1;
    idx = a[9:0];
    if (!oor(a)) begin
      if (!ub) mem_m[idx][15:8] = d[15:8];
      if (!lb) mem_m[idx][7:0]  = d[7:0];
    end
    check("wr_err_range", Err_range, oor(a));
    check("wr_done_idle", Busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [19:0] a;
    logic [15:0] e0, e1;
    int r;
    Reset = 0; CE = 1; UB = 1; LB = 1; OE = 1; WE = 1; ADDR = '0;
    Init_WE = 0; Init_ADDR = '0; Init_Data = '0; tb_drv = 0; tb_dat = '0;
    repeat (2) @(posedge Clk); #1;
    check("reset_busy", Busy, 0);
    check("reset_err_range", Err_range, 0);
    check("reset_err_conflict", Err_conflict, 0);
    check("reset_data_z", Data, 16'hFFFF);
    Reset = 1;

    for (int i = 0; i < 32; i++) init_write(AW'(i), 16'($urandom));
    mon_en = 1;

    // Preloaded word read back with full lanes.
    init_write(10'h012, 16'h1234);
    do_read(20'h00012, 0, 0);

    // Lower-lane-only write over an existing word.
    init_write(10'h005, 16'h5500);
    do_write(20'h00005, 16'hABCD, 1, 0, 2);
    do_read(20'h00005, 0, 0);

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      a = 20'($urandom_range(0, 31));
      if (r == 9) a = a | (20'd1 << $urandom_range(AW, 19));
      if (r < 4 || r == 9) do_read(a, 1'($urandom), 1'($urandom));
      else if (r < 8)      do_write(a, 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 3));
      else                 init_write(a[AW-1:0], 16'($urandom));
    end
    check("no_conflict_yet", Err_conflict, 0);

    // Out-of-range read fills zeros; out-of-range write leaves the aliased word alone.
    do_read(20'h40003, 0, 0);
    do_write(20'h40003, 16'hDEAD, 0, 0, 1);
    do_read(20'h00003, 0, 0);

    // CE/OE/WE all low: write wins, bus never driven, sticky flag.
    @(posedge Clk); #1;
    CE = 0; OE = 0; WE = 0; UB = 1; LB = 1; ADDR = 20'h00007;
    @(negedge Clk);
    check("conflict_bus_z0", Data, 16'hFFFF);
    @(posedge Clk); #1;
    check("conflict_flag", Err_conflict, 1);
    check("conflict_busy", Busy, 1);
    @(negedge Clk);
    check("conflict_bus_z1", Data, 16'hFFFF);
    CE = 1; OE = 1; WE = 1;
    @(posedge Clk); #1;
    check("conflict_idle", Busy, 0);
    do_read(20'h00007, 0, 0);
    check("conflict_sticky", Err_conflict, 1);

    // Address change while driving; init strobes with CE low must be ignored.
    mon_en = 0;
    e0 = mem_m[16];
    e1 = mem_m[17];
    @(posedge Clk); #1;
    CE = 0; OE = 0; WE = 1; UB = 0; LB = 0; ADDR = 20'h00010;
    repeat (LAT + 1) @(posedge Clk);
    @(negedge Clk);
    check("t6_drive_old", Data, e0);
    ADDR = 20'h00011; Init_WE = 1; Init_ADDR = 10'h011; Init_Data = ~e1;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge Clk);
      check("t6_gap_z", Data, 16'hFFFF);
    end
    @(negedge Clk);
    check("t6_drive_new", Data, e1);
    CE = 1; OE = 1; Init_WE = 0;
    @(negedge Clk);
    check("t6_released", Data, 16'hFFFF);
    mon_en = 1;
    do_read(20'h00011, 0, 0);

    // Reset in READ_WAIT and in DRIVE; array contents must survive.
    mon_en = 0;
    @(posedge Clk); #1;
    CE = 0; OE = 0; WE = 1; UB = 0; LB = 0; ADDR = 20'h00014;
    @(posedge Clk); #1;
    check("t5_wait_busy", Busy, 1);
    Reset = 0;
    #1;
    check("t5_rst_busy", Busy, 0);
    check("t5_rst_data_z", Data, 16'hFFFF);
    check("t5_rst_conflict", Err_conflict, 0);
    CE = 1; OE = 1;
    @(posedge Clk); #1;
    Reset = 1;
    @(posedge Clk); #1;
    CE = 0; OE = 0; ADDR = 20'h00015;
    repeat (LAT + 1) @(posedge Clk);
    @(negedge Clk);
    check("t5_drive", Data, mem_m[21]);
    Reset = 0;
    #1;
    check("t5_rst_drive_z", Data, 16'hFFFF);
    check("t5_rst_drive_busy", Busy, 0);
    CE = 1; OE = 1;
    @(posedge Clk); #1;
    Reset = 1;
    mon_en = 1;
    do_read(20'h00014, 0, 0);
    do_read(20'h00015, 0, 0);

    repeat (3) @(posedge Clk);
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
